// File: rtl/board_io_pkg.sv
// Shared types and constants for the board input controller.
package board_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } btn_state_e;

  localparam int unsigned NUM_BTN = 5;
  localparam int unsigned NUM_SW  = 16;

  localparam int unsigned BTN_U = 0;
  localparam int unsigned BTN_L = 1;
  localparam int unsigned BTN_R = 2;
  localparam int unsigned BTN_D = 3;
  localparam int unsigned BTN_C = 4;

endpackage

// File: rtl/debounce_cell.sv
// One push-button: synchronizer, press/release debounce FSM, level and press pulse.
module debounce_cell
  import board_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic level_o,
  output logic pulse_o
);

  localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_MAX  = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   din_s;
  btn_state_e             state_q;
  logic [CW-1:0]          cnt_q;
  logic                   level_q;
  logic                   pulse_q;

  assign din_s   = sync_q[SYNC_STAGES-1];
  assign level_o = level_q;
  assign pulse_o = pulse_q;

  // The IDLE/PRESSED sample that leaves the stable state counts as the first of the run.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din_i};
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (din_s) begin
            state_q <= WAIT_PRESS;
            cnt_q   <= '0;
          end
        end
        WAIT_PRESS: begin
          if (!din_s) begin
            state_q <= IDLE;
          end else if (cnt_q >= CNT_LAST) begin
            state_q <= PRESSED;
            level_q <= 1'b1;
            pulse_q <= 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!din_s) begin
            state_q <= WAIT_RELEASE;
            cnt_q   <= '0;
          end
        end
        WAIT_RELEASE: begin
          if (din_s) begin
            state_q <= PRESSED;
          end else if (cnt_q >= CNT_LAST) begin
            state_q <= IDLE;
            level_q <= 1'b0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/board_input_ctrl.sv
// Board inputs: five debounced push-buttons and a debounced 16-bit switch word with valid/ready.
module board_input_ctrl
  import board_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_BTN-1:0]   btn,
  input  logic [NUM_SW-1:0]    sw,
  output logic [NUM_BTN-1:0]   btn_level,
  output logic [NUM_BTN-1:0]   btn_pulse,
  output logic [NUM_SW-1:0]    sw_data,
  output logic                 sw_valid,
  input  logic                 sw_ready
);

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_cell (
      .clk     (clk),
      .reset   (reset),
      .din_i   (btn[i]),
      .level_o (btn_level[i]),
      .pulse_o (btn_pulse[i])
    );
  end

  logic [SYNC_STAGES-1:0][NUM_SW-1:0] sw_sync_q;
  logic [NUM_SW-1:0]                  sw_s;
  logic [NUM_SW-1:0]                  sw_prev_q;
  logic [NUM_SW-1:0]                  sw_data_q;
  logic [CW-1:0]                      sw_cnt_q;
  logic                               sw_valid_q;
  logic                               sw_qual_d;

  assign sw_s     = sw_sync_q[SYNC_STAGES-1];
  assign sw_data  = sw_data_q;
  assign sw_valid = sw_valid_q;

  always_comb begin
    sw_qual_d = 1'b0;
    if ((sw_s == sw_prev_q) && (sw_cnt_q >= CNT_LAST) && (sw_s != sw_data_q)) begin
      sw_qual_d = 1'b1;
    end
  end

  // A handshake edge never loads; a still-qualified word is taken on the following edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_sync_q  <= '0;
      sw_prev_q  <= '0;
      sw_cnt_q   <= '0;
      sw_data_q  <= '0;
      sw_valid_q <= 1'b0;
    end else begin
      sw_sync_q <= {sw_sync_q[SYNC_STAGES-2:0], sw};
      if (sw_s != sw_prev_q) begin
        sw_prev_q <= sw_s;
        sw_cnt_q  <= '0;
      end else if (sw_cnt_q != CNT_MAX) begin
        sw_cnt_q <= sw_cnt_q + 1'b1;
      end
      if (sw_valid_q && sw_ready) begin
        sw_valid_q <= 1'b0;
      end else if (!sw_valid_q && sw_qual_d) begin
        sw_data_q  <= sw_s;
        sw_valid_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_board_input_ctrl.sv
// Scoreboard bench for board_input_ctrl: run-length/window reference model plus directed scenarios.
module tb_board_input_ctrl;

  localparam int unsigned D  = 4;
  localparam int unsigned SS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  btn;
  logic [15:0] sw;
  logic        sw_ready;
  logic [4:0]  btn_level;
  logic [4:0]  btn_pulse;
  logic [15:0] sw_data;
  logic        sw_valid;

  board_input_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .SYNC_STAGES     (SS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .sw        (sw),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse),
    .sw_data   (sw_data),
    .sw_valid  (sw_valid),
    .sw_ready  (sw_ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [4:0] mask;
  } pulse_t;

  pulse_t      pq[$];
  logic [15:0] swq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a button flips once its delayed input has disagreed with the
  // debounced level for D+1 consecutive samples; a switch word qualifies when the
  // last D+1 delayed samples are identical and differ from the held word.
  logic [4:0]  bh[SS];
  logic [15:0] wh[SS];
  logic [15:0] win[$];
  logic [4:0]  m_level = '0;
  int          run[5];
  logic [15:0] m_data  = '0;
  logic        m_valid = 1'b0;

  always @(posedge clk) begin : model
    logic [4:0]  bs;
    logic [15:0] ws;
    logic [4:0]  mask;
    logic        qual;
    cyc++;
    bs = bh[SS-1];
    ws = wh[SS-1];
    for (int k = SS - 1; k > 0; k--) begin
      bh[k] = bh[k-1];
      wh[k] = wh[k-1];
    end
    bh[0] = btn;
    wh[0] = sw;
    if (reset) begin
      for (int k = 0; k < SS; k++) begin
        bh[k] = '0;
        wh[k] = '0;
      end
      win.delete();
      m_level = '0;
      for (int i = 0; i < 5; i++) run[i] = 0;
      m_data  = '0;
      m_valid = 1'b0;
    end else begin
      mask = '0;
      for (int i = 0; i < 5; i++) begin
        if (bs[i] != m_level[i]) run[i]++;
        else run[i] = 0;
        if (run[i] == D + 1) begin
          m_level[i] = ~m_level[i];
          run[i] = 0;
          if (m_level[i]) mask[i] = 1'b1;
        end
      end
      if (mask != 0) pq.push_back('{cyc: cyc, mask: mask});
      win.push_back(ws);
      if (win.size() > D + 1) void'(win.pop_front());
      qual = (win.size() == D + 1) && (ws != m_data);
      foreach (win[k]) if (win[k] != ws) qual = 1'b0;
      if (m_valid && sw_ready) begin
        m_valid = 1'b0;
      end else if (!m_valid && qual) begin
        m_data  = ws;
        m_valid = 1'b1;
        swq.push_back(ws);
      end
    end
  end

  logic        prev_v = 1'b0;
  logic [15:0] cur_w  = '0;

  always @(negedge clk) begin : monitor
    logic [4:0] exp_p;
    pulse_t     pe;
    while (pq.size() > 0 && pq[0].cyc < cyc) begin
      pe = pq.pop_front();
      chk("btn_pulse_missing", 32'(btn_pulse), 32'(pe.mask));
    end
    exp_p = '0;
    if (pq.size() > 0 && pq[0].cyc == cyc) begin
      pe = pq.pop_front();
      exp_p = pe.mask;
    end
    if (btn_pulse !== 5'b0 || exp_p != 0) chk("btn_pulse", 32'(btn_pulse), 32'(exp_p));
    chk("btn_level", 32'(btn_level), 32'(m_level));
    chk("sw_valid", 32'(sw_valid), 32'(m_valid));
    if (sw_valid === 1'b1 && !prev_v) begin
      if (swq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sw_txn_unexpected: got data %0h expected no pending word (cycle %0d)", sw_data, cyc);
      end else begin
        cur_w = swq.pop_front();
      end
    end
    if (sw_valid === 1'b1) chk("sw_data", 32'(sw_data), 32'(cur_w));
    prev_v = (sw_valid === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic observe(input int n, input int b, output int cnt, output int first);
    cnt   = 0;
    first = -1;
    repeat (n) begin
      @(negedge clk);
      if (btn_pulse[b] === 1'b1) begin
        cnt++;
        if (first < 0) first = cyc;
      end
    end
  endtask

  int hold[5];
  int shold;

  initial begin : stim
    int c1, c2, c3, c4, f, t0, lat;
    bit got;
    reset = 1'b1; btn = '0; sw = '0; sw_ready = 1'b0;
    tick(3);
    chk("reset_level", 32'(btn_level), 0);
    chk("reset_pulse", 32'(btn_pulse), 0);
    chk("reset_sw_data", 32'(sw_data), 0);
    chk("reset_sw_valid", 32'(sw_valid), 0);
    reset = 1'b0;
    tick(3);

    // btn C held 10 cycles, then released
    btn[4] = 1'b1; t0 = cyc;
    observe(10, 4, c1, f);
    lat = f - (t0 + 1);
    chk("c_pulse_count_hold", 32'(c1), 1);
    chk("c_latency_in_range", 32'(lat >= 5 && lat <= 7), 1);
    chk("c_level_held", 32'(btn_level[4]), 1);
    btn[4] = 1'b0;
    observe(12, 4, c2, f);
    chk("c_no_release_pulse", 32'(c2), 0);
    chk("c_level_released", 32'(btn_level[4]), 0);

    // btn U glitches: 3 high, 2 low, 3 high
    btn[0] = 1'b1; observe(3, 0, c1, f);
    btn[0] = 1'b0; observe(2, 0, c2, f);
    btn[0] = 1'b1; observe(3, 0, c3, f);
    btn[0] = 1'b0; observe(10, 0, c4, f);
    chk("u_glitch_pulses", 32'(c1 + c2 + c3 + c4), 0);
    chk("u_glitch_level", 32'(btn_level[0]), 0);

    // switch word handshake
    sw = 16'hA5A5; tick(12);
    chk("sw_first_valid", 32'(sw_valid), 1);
    chk("sw_first_data", 32'(sw_data), 32'h0000A5A5);
    sw = 16'h00FF; tick(12);
    chk("sw_frozen_valid", 32'(sw_valid), 1);
    chk("sw_frozen_data", 32'(sw_data), 32'h0000A5A5);
    sw_ready = 1'b1; tick(1);
    sw_ready = 1'b0;
    chk("sw_gap_valid", 32'(sw_valid), 0);
    tick(1);
    chk("sw_second_valid", 32'(sw_valid), 1);
    chk("sw_second_data", 32'(sw_data), 32'h000000FF);

    // all five buttons at once
    btn = 5'h1F;
    got = 1'b0;
    for (int k = 0; k < 15 && !got; k++) begin
      @(negedge clk);
      if (btn_pulse !== 5'b0) begin
        got = 1'b1;
        chk("all_pulses_same_cycle", 32'(btn_pulse), 32'h1F);
      end
    end
    if (!got) chk("all_pulses_timeout", 32'(btn_pulse), 32'h1F);
    tick(4);
    btn = '0; tick(12);

    // reset two cycles into WAIT_PRESS with btn R held
    btn[2] = 1'b1; tick(4);
    reset = 1'b1; tick(2);
    chk("midreset_level", 32'(btn_level), 0);
    chk("midreset_pulse", 32'(btn_pulse), 0);
    chk("midreset_sw_valid", 32'(sw_valid), 0);
    chk("midreset_sw_data", 32'(sw_data), 0);
    reset = 1'b0; t0 = cyc;
    observe(15, 2, c1, f);
    chk("r_pulse_after_reset", 32'(c1), 1);
    chk("r_latency_in_range", 32'((f - (t0 + 1)) >= 5 && (f - (t0 + 1)) <= 7), 1);
    chk("sw_reported_after_reset", 32'(sw_data), 32'h000000FF);
    btn = '0; sw_ready = 1'b1; tick(3);
    sw_ready = 1'b0; tick(12);

    // randomized phase
    for (int i = 0; i < 5; i++) hold[i] = 0;
    shold = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 5; i++) begin
        if (hold[i] == 0) begin
          btn[i] = ~btn[i];
          hold[i] = int'($urandom_range(1, 9));
        end else begin
          hold[i]--;
        end
      end
      if (shold == 0) begin
        if ($urandom_range(0, 2) == 0) sw = 16'($urandom);
        else sw = sw ^ (16'h1 << $urandom_range(0, 15));
        shold = int'($urandom_range(1, 12));
      end else begin
        shold--;
      end
      sw_ready = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 299) == 0);
      tick(1);
    end

    reset = 1'b0; btn = '0; sw_ready = 1'b1;
    tick(30);
    chk("pulse_queue_drained", 32'(pq.size()), 0);
    chk("sw_queue_drained", 32'(swq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/board_input_ctrl.md
BOARD_INPUT_CTRL -- requirements
Module: board_input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the stable-input cycles needed before a change is accepted (10 ms at 100 MHz); minimum value 2.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer flop depth on every board input; minimum value 2.
REQ-003 clk  input  1  SHALL be the single system clock; all flops clock on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 btn  input  5  SHALL carry the raw asynchronous push-buttons, in order {U,L,R,D,C}; 1 means pressed.
REQ-006 sw  input  16  SHALL carry the raw asynchronous slide switches.
REQ-007 btn_level  output  5  SHALL carry the debounced button state.
REQ-008 btn_pulse  output  5  SHALL carry a one-cycle pulse per accepted press, per button.
REQ-009 sw_data  output  16  SHALL carry the last accepted debounced switch word.
REQ-010 sw_valid  output  1  SHALL mark a new sw_data word pending for the consumer.
REQ-011 sw_ready  input  1  SHALL be the consumer accept strobe for sw_data.

Function
REQ-012 Each btn and sw bit SHALL pass through SYNC_STAGES flops before any other logic; no raw input reaches an FSM or comparator.
REQ-013 Each button SHALL run an independent FSM with states IDLE, WAIT_PRESS, PRESSED and WAIT_RELEASE.
REQ-014 In IDLE, a synchronized 1 SHALL move the button FSM to WAIT_PRESS and clear its counter.
REQ-015 In WAIT_PRESS, a synchronized 0 SHALL return the FSM to IDLE, and DEBOUNCE_CYCLES consecutive 1s SHALL move it to PRESSED.
REQ-016 On the WAIT_PRESS->PRESSED transition, btn_pulse[i] SHALL be 1 for exactly one cycle, and btn_level[i] SHALL become 1 in that same cycle.
REQ-017 PRESSED and WAIT_RELEASE SHALL mirror REQ-014/015 with inverted polarity; WAIT_RELEASE->IDLE SHALL clear btn_level[i] and SHALL produce no pulse.
REQ-018 Press-to-pulse latency SHALL be SYNC_STAGES + DEBOUNCE_CYCLES cycles, +/-1 cycle for counter start.
REQ-019 Each debounce counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide and SHALL saturate, never wrap.
REQ-020 Any glitch shorter than DEBOUNCE_CYCLES SHALL leave btn_level and btn_pulse unchanged.
REQ-021 The 16 synchronized switches SHALL be debounced as one word: a shared counter SHALL restart whenever the word changes, and the word SHALL be accepted after DEBOUNCE_CYCLES stable cycles in which it differs from sw_data.
REQ-022 When sw_valid is 0, acceptance SHALL load sw_data and set sw_valid on the next cycle.
REQ-023 When sw_valid is 1, sw_data SHALL stay frozen and acceptance SHALL be deferred until the handshake completes.
REQ-024 The handshake SHALL complete when sw_valid and sw_ready are both 1 at a clock edge, and sw_valid SHALL clear on that edge.
REQ-025 If a handshake completes while a different stable word is already qualified, that word SHALL be loaded and sw_valid re-asserted on the next edge (a 1-cycle valid gap).
REQ-026 sw_ready SHALL be ignored while sw_valid is 0.
REQ-027 Simultaneous events on different buttons SHALL be handled independently, with no priority between them.

Reset
REQ-028 On reset, all FSMs SHALL go to IDLE, all counters to 0 and all synchronizer flops to 0.
REQ-029 On reset, btn_level, btn_pulse, sw_data and sw_valid SHALL all be 0.
REQ-030 Reset asserted mid-debounce or mid-handshake SHALL abort that operation; no pulse or valid is produced for it afterward.
REQ-031 After reset, switches already set SHALL be reported through the normal debounce/handshake path, since the reset value of sw_data is 0.

Structure
REQ-032 The button state enum and the button index constants BTN_U, BTN_L, BTN_R, BTN_D and BTN_C SHALL live in the shared package board_io_pkg.
REQ-033 The per-bit logic (synchronizer, FSM, counter) SHALL be one sub-module, debounce_cell, instantiated 5 times.
REQ-034 Switch-word debounce and the handshake SHALL be written inline in board_input_ctrl.
REQ-035 The total implementation SHALL be about 150-300 lines of RTL.

Verification
REQ-036 The bench SHALL run with DEBOUNCE_CYCLES=4 and SYNC_STAGES=2.
REQ-037 Scenario: btn[C] held high for 10 cycles -> exactly one btn_pulse[4] about 6 cycles after the rise, and btn_level[4]=1 until a release followed by 4 stable cycles.
REQ-038 Scenario: btn[U] high for 3 cycles, low, then high for 3 cycles -> no pulse and btn_level[0] stays 0.
REQ-039 Scenario: sw=16'hA5A5 stable with sw_ready=0 -> sw_valid=1 and sw_data=A5A5; then sw changes to 16'h00FF -> sw_data holds A5A5; then sw_ready pulses for 1 cycle -> sw_valid drops for 1 cycle, then returns with sw_data=00FF.
REQ-040 Scenario: all 5 buttons pressed in the same cycle -> all 5 pulses occur in the same cycle.
REQ-041 Scenario: reset asserted 2 cycles into WAIT_PRESS with the button still held -> outputs 0 during reset, and exactly one pulse follows a full debounce period after reset release.
